// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester round-robin arbiter and sequencer for a shared
// 32-bit ALU. Each request is accepted in IDLE and drives the ALU from
// registered operands for one EXEC cycle. The result is then held in RESP
// until the owning requester takes it.
// Optional feature: define ALU_ARB_ILLEGAL_EN to trap the reserved op codes
// 01010, 01011 and 10110..11111. A trapped op runs addu on the ALU, ignores
// the ALU output and returns result=0, zero=1, err=1.
module alu_share_arb #(
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_ctr,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamt,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_ctr,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamt,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_err,

    output logic [4:0]  alu_ctr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        ptr;        // requester that wins a tie
    logic        owner;      // requester of the operation in flight
    logic        ill_q;      // operation in flight carries an illegal code

    logic        grant_any;
    logic        grant;
    logic        accept;
    logic [4:0]  sel_ctr;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [4:0]  sel_shamt;
    logic        sel_ill;
    logic        owner_ready;

    // Grant selection: a lone valid wins, a tie goes to the priority pointer
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = !rst && (state == IDLE) && grant_any && !grant;
    assign req1_ready = !rst && (state == IDLE) && grant_any &&  grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Operand mux towards the capture registers, driven by the current grant
    always_comb begin
        sel_ctr   = req0_ctr;
        sel_a     = req0_a;
        sel_b     = req0_b;
        sel_shamt = req0_shamt;
        if (grant) begin
            sel_ctr   = req1_ctr;
            sel_a     = req1_a;
            sel_b     = req1_b;
            sel_shamt = req1_shamt;
        end
    end

`ifdef ALU_ARB_ILLEGAL_EN
    assign sel_ill = (sel_ctr == 5'b01010) || (sel_ctr == 5'b01011) ||
                     (sel_ctr >= 5'b10110);
`else
    assign sel_ill = 1'b0;
`endif

    // Handshake of the owning requester on the response channel
    always_comb begin
        owner_ready = owner ? rsp1_ready : rsp0_ready;
    end

    // Sequencer: capture on accept, run the ALU for one cycle, hold the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= (RR_INIT != 0);
            owner       <= 1'b0;
            ill_q       <= 1'b0;
            alu_ctr     <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_shamt   <= '0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_zero   <= 1'b0;
            rsp0_err    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_zero   <= 1'b0;
            rsp1_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner     <= grant;
                        ptr       <= ~grant;
                        ill_q     <= sel_ill;
                        // an illegal code runs a harmless addu on the ALU
                        alu_ctr   <= sel_ill ? 5'b00000 : sel_ctr;
                        alu_a     <= sel_a;
                        alu_b     <= sel_b;
                        alu_shamt <= sel_shamt;
                        state     <= EXEC;
                    end
                end

                EXEC: begin
                    if (!owner) begin
                        rsp0_valid  <= 1'b1;
                        rsp0_result <= ill_q ? '0 : alu_result;
                        rsp0_zero   <= ill_q ? 1'b1 : alu_zero;
                        rsp0_err    <= ill_q;
                    end else begin
                        rsp1_valid  <= 1'b1;
                        rsp1_result <= ill_q ? '0 : alu_result;
                        rsp1_zero   <= ill_q ? 1'b1 : alu_zero;
                        rsp1_err    <= ill_q;
                    end
                    state <= RESP;
                end

                RESP: begin
                    if (owner_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb. A behavioural ALU stands in for the
// real one. Table vectors, hand-written corner sequences and a randomized
// phase are all checked against expectations computed in this file.
module tb_alu_share_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic [4:0]  req0_ctr, req0_shamt;
    logic [31:0] req0_a, req0_b, rsp0_result;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [4:0]  req1_ctr, req1_shamt;
    logic [31:0] req1_a, req1_b, rsp1_result;
    logic [4:0]  alu_ctr, alu_shamt;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    alu_share_arb #(.RR_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctr(req0_ctr),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctr(req1_ctr),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_ctr(alu_ctr), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Stand-in ALU: shifts act on b by shamt; unknown codes return ~a
    function automatic logic [31:0] alu_f(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        case (c)
            5'b00000: return a + b;
            5'b00001: return a - b;
            5'b00010: return a & b;
            5'b00011: return a | b;
            5'b00100: return a ^ b;
            5'b00101: return ~(a | b);
            5'b00110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'b00111: return (a < b) ? 32'd1 : 32'd0;
            5'b01000: return b << sh;
            5'b01001: return b >> sh;
            5'b01100: return 32'($signed(b) >>> sh);
            5'b10101: return a ^ b;
            default:  return ~a;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_f(alu_ctr, alu_a, alu_b, alu_shamt);
        alu_zero   = (alu_result == 32'd0);
    end

    function automatic logic ref_ill(input logic [4:0] c);
`ifdef ALU_ARB_ILLEGAL_EN
        return (c == 5'd10) || (c == 5'd11) || (c >= 5'd22);
`else
        return 1'b0;
`endif
    endfunction

    // Expected response {err, zero, result} for one operation
    function automatic logic [33:0] ref_op(input logic [4:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        if (ref_ill(c)) return {1'b1, 1'b1, 32'd0};
        r = alu_f(c, a, b, sh);
        return {1'b0, (r == 32'd0), r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs;
        req0_valid = 1'b0; req0_ctr = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
        req1_valid = 1'b0; req1_ctr = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One operation through requester 'who' with latency and ALU-drive checks
    task automatic run_op(input logic who, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          output logic [31:0] res, output logic z, output logic e,
                          output logic ok);
        int n;
        ok = 1'b0; res = '0; z = 1'b0; e = 1'b0;
        @(posedge clk); #1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        if (!who) begin
            req0_valid = 1'b1; req0_ctr = c; req0_a = a; req0_b = b; req0_shamt = sh;
        end else begin
            req1_valid = 1'b1; req1_ctr = c; req1_a = a; req1_b = b; req1_shamt = sh;
        end
        n = 0;
        @(negedge clk);
        while (!(who ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL run_op accept timeout: got no ready expected ready");
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("exec alu_ctr", 32'(alu_ctr), ref_ill(c) ? 32'd0 : 32'(c));
        chk("exec alu_a", alu_a, a);
        chk("exec alu_b", alu_b, b);
        chk("exec alu_shamt", 32'(alu_shamt), 32'(sh));
        n = 0;
        while (!(who ? rsp1_valid : rsp0_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL run_op response timeout: got no rsp_valid expected rsp_valid");
            return;
        end
        chk("response latency", 32'(n), 32'd1);
        res = who ? rsp1_result : rsp0_result;
        z   = who ? rsp1_zero : rsp0_zero;
        e   = who ? rsp1_err : rsp0_err;
        ok  = 1'b1;
    endtask

    typedef struct {
        logic        who;
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] er;
        logic        ez;
        logic        ee;
    } vec_t;

    vec_t vt[$];

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic        z, e, ok;
        int          g[$];
        int          both_hi;
        int          n;
        logic        m_ptr, m_owner, eg0, eg1;
        int          m_phase;
        logic [33:0] m_exp;

        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #2;
        chk("rst ready0", req0_ready, 1'b0);
        chk("rst ready1", req1_ready, 1'b0);
        chk("rst rsp0_valid", rsp0_valid, 1'b0);
        chk("rst rsp1_valid", rsp1_valid, 1'b0);
        chk("rst rsp0_result", rsp0_result, 32'd0);
        chk("rst rsp1_zero", rsp1_zero, 1'b0);
        chk("rst rsp0_err", rsp0_err, 1'b0);
        chk("rst alu_ctr", 32'(alu_ctr), 32'd0);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst alu_b", alu_b, 32'd0);
        chk("rst alu_shamt", 32'(alu_shamt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();

        // ---------------- single request latency ----------------
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_ctr = 5'b00000; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        chk("t1 ready0", req0_ready, 1'b1);
        chk("t1 ready1", req1_ready, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1 alu_a", alu_a, 32'd5);
        chk("t1 alu_b", alu_b, 32'd7);
        chk("t1 exec rsp0_valid", rsp0_valid, 1'b0);
        @(negedge clk);
        chk("t1 rsp0_valid", rsp0_valid, 1'b1);
        chk("t1 result", rsp0_result, 32'd12);
        chk("t1 zero", rsp0_zero, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1 after take rsp0_valid", rsp0_valid, 1'b0);

        // ---------------- contention ----------------
        do_reset();
        req0_valid = 1'b1; req0_ctr = 5'b00001; req0_a = 32'd3; req0_b = 32'd3;
        req1_valid = 1'b1; req1_ctr = 5'b00011; req1_a = 32'hF0; req1_b = 32'h0F;
        @(negedge clk);
        chk("cont ready0", req0_ready, 1'b1);
        chk("cont ready1", req1_ready, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("cont exec rsp1_valid", rsp1_valid, 1'b0);
        chk("cont exec ready1", req1_ready, 1'b0);
        @(negedge clk);
        chk("cont rsp0_valid", rsp0_valid, 1'b1);
        chk("cont rsp0_result", rsp0_result, 32'd0);
        chk("cont rsp0_zero", rsp0_zero, 1'b1);
        chk("cont resp rsp1_valid", rsp1_valid, 1'b0);
        chk("cont resp ready1", req1_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cont ready1 next", req1_ready, 1'b1);
        chk("cont rsp0 cleared", rsp0_valid, 1'b0);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("cont rsp1_valid", rsp1_valid, 1'b1);
        chk("cont rsp1_result", rsp1_result, 32'h000000FF);
        chk("cont rsp1_zero", rsp1_zero, 1'b0);
        chk("cont other rsp0_valid", rsp0_valid, 1'b0);

        // ---------------- back-pressure ----------------
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_ctr = 5'b01100; req1_a = 32'h80000000;
        req1_b = 32'h80000000; req1_shamt = 5'd4;
        rsp1_ready = 1'b0;
        @(negedge clk);
        chk("bp ready1", req1_ready, 1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_ctr = 5'b00000; req0_a = 32'd1; req0_b = 32'd1;
        req0_shamt = 5'd0;
        @(negedge clk);
        chk("bp exec ready0", req0_ready, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp hold rsp1_valid", rsp1_valid, 1'b1);
            chk("bp hold rsp1_result", rsp1_result, 32'hF8000000);
            chk("bp hold ready0", req0_ready, 1'b0);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp release rsp1_valid", rsp1_valid, 1'b1);
        chk("bp release ready0", req0_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp idle ready0", req0_ready, 1'b1);
        chk("bp idle rsp1_valid", rsp1_valid, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp pending rsp0_valid", rsp0_valid, 1'b1);
        chk("bp pending rsp0_result", rsp0_result, 32'd2);

        // ---------------- fairness ----------------
        do_reset();
        req0_valid = 1'b1; req0_ctr = 5'b00000; req0_a = 32'd1; req0_b = 32'd0;
        req1_valid = 1'b1; req1_ctr = 5'b00000; req1_a = 32'd2; req1_b = 32'd0;
        n = 0; both_hi = 0;
        while (g.size() < 6 && n < 60) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_hi++;
            if (req0_ready) g.push_back(0);
            else if (req1_ready) g.push_back(1);
            n++;
        end
        chk("fair grant count", 32'(g.size()), 32'd6);
        chk("fair both ready", 32'(both_hi), 32'd0);
        for (int i = 0; i < g.size(); i++) chk("fair grant order", 32'(g[i]), 32'(i % 2));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // ---------------- async reset during EXEC and RESP ----------------
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req0_ctr = 5'b00000; req0_a = 32'd9; req0_b = 32'd9;
        @(negedge clk);
        chk("rx ready0", req0_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #2;
        chk("rx exec alu_a", alu_a, 32'd9);
        rst = 1'b1;
        #1;
        chk("rx rsp0_valid", rsp0_valid, 1'b0);
        chk("rx rsp1_valid", rsp1_valid, 1'b0);
        chk("rx alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rx no response", rsp0_valid, 1'b0);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("rx ptr init ready0", req0_ready, 1'b1);
        chk("rx ptr init ready1", req1_ready, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_ctr = 5'b00000; req1_a = 32'd4; req1_b = 32'd4;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rx2 rsp1_valid before", rsp1_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("rx2 rsp1_valid", rsp1_valid, 1'b0);
        chk("rx2 rsp1_result", rsp1_result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();

        // ---------------- table-driven vectors ----------------
        vt.push_back('{1'b0, 5'b00000, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0});
        vt.push_back('{1'b1, 5'b00001, 32'd3, 32'd3, 5'd0, 32'd0, 1'b1, 1'b0});
        vt.push_back('{1'b0, 5'b00011, 32'hF0, 32'h0F, 5'd0, 32'hFF, 1'b0, 1'b0});
        vt.push_back('{1'b1, 5'b01100, 32'h80000000, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0});
        vt.push_back('{1'b0, 5'b00010, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, 32'h0F0F0000, 1'b0, 1'b0});
        vt.push_back('{1'b1, 5'b01000, 32'd0, 32'd1, 5'd31, 32'h80000000, 1'b0, 1'b0});
        vt.push_back('{1'b0, 5'b01001, 32'd0, 32'h80000000, 5'd31, 32'd1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 5'b00110, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 5'b00111, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 5'b10101, 32'h12345678, 32'h0000FFFF, 5'd0, 32'h1234A987, 1'b0, 1'b0});
        vt.push_back('{1'b0, 5'b00000, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 5'b00101, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0});
        vt.push_back('{1'b0, 5'b10100, 32'd0, 32'd5, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0});
`ifdef ALU_ARB_ILLEGAL_EN
        vt.push_back('{1'b0, 5'b01011, 32'd3, 32'd4, 5'd0, 32'd0, 1'b1, 1'b1});
        vt.push_back('{1'b1, 5'b11111, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b1});
        vt.push_back('{1'b0, 5'b01010, 32'hFFFFFFFF, 32'd0, 5'd0, 32'd0, 1'b1, 1'b1});
        vt.push_back('{1'b1, 5'b10110, 32'd1, 32'd1, 5'd0, 32'd0, 1'b1, 1'b1});
`else
        vt.push_back('{1'b0, 5'b01011, 32'd3, 32'd4, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0});
        vt.push_back('{1'b1, 5'b11111, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0});
        vt.push_back('{1'b0, 5'b01010, 32'hFFFFFFFF, 32'd0, 5'd0, 32'd0, 1'b1, 1'b0});
        vt.push_back('{1'b1, 5'b10110, 32'd1, 32'd1, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0});
`endif
        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i].who, vt[i].c, vt[i].a, vt[i].b, vt[i].sh, res, z, e, ok);
            if (ok) begin
                chk($sformatf("vec%0d result", i), res, vt[i].er);
                chk($sformatf("vec%0d zero", i), 32'(z), 32'(vt[i].ez));
                chk($sformatf("vec%0d err", i), 32'(e), 32'(vt[i].ee));
            end
        end

        // ---------------- randomized against reference ----------------
        do_reset();
        m_ptr = 1'b0; m_owner = 1'b0; m_phase = 0; m_exp = '0;
        for (int cy = 0; cy < 600; cy++) begin
            @(posedge clk); #1;
            req0_valid = 1'($urandom_range(0, 1));
            req0_ctr   = 5'($urandom_range(0, 31));
            req0_a     = $urandom;
            req0_b     = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req0_shamt = 5'($urandom_range(0, 31));
            req1_valid = 1'($urandom_range(0, 1));
            req1_ctr   = 5'($urandom_range(0, 31));
            req1_a     = $urandom;
            req1_b     = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            req1_shamt = 5'($urandom_range(0, 31));
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            eg0 = 1'b0; eg1 = 1'b0;
            if (m_phase == 0) begin
                if (req0_valid && req1_valid) begin
                    if (m_ptr) eg1 = 1'b1; else eg0 = 1'b1;
                end else if (req0_valid) begin
                    eg0 = 1'b1;
                end else if (req1_valid) begin
                    eg1 = 1'b1;
                end
            end
            chk("rnd ready0", req0_ready, eg0);
            chk("rnd ready1", req1_ready, eg1);
            chk("rnd rsp0_valid", rsp0_valid, (m_phase == 2) && !m_owner);
            chk("rnd rsp1_valid", rsp1_valid, (m_phase == 2) && m_owner);
            if (m_phase == 2) begin
                if (!m_owner) begin
                    chk("rnd rsp0_result", rsp0_result, m_exp[31:0]);
                    chk("rnd rsp0_zero", rsp0_zero, m_exp[32]);
                    chk("rnd rsp0_err", rsp0_err, m_exp[33]);
                end else begin
                    chk("rnd rsp1_result", rsp1_result, m_exp[31:0]);
                    chk("rnd rsp1_zero", rsp1_zero, m_exp[32]);
                    chk("rnd rsp1_err", rsp1_err, m_exp[33]);
                end
            end
            case (m_phase)
                0: if (eg0 || eg1) begin
                    m_owner = eg1;
                    m_exp   = eg1 ? ref_op(req1_ctr, req1_a, req1_b, req1_shamt)
                                  : ref_op(req0_ctr, req0_a, req0_b, req0_shamt);
                    m_ptr   = !eg1;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (m_owner ? rsp1_ready : rsp0_ready) m_phase = 0;
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
